// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction ROM/cache.
//   addr  : fetch address (driven by the fetch stage, equals pc)
//   rdata : instruction word at addr, combinational read
// The master modport is used by if_stage; the slave modport by the memory.
interface if_stage_if;
    logic [31:0] addr;
    logic [31:0] rdata;

    modport master (output addr, input  rdata);
    modport slave  (input  addr, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the pipelined MIPS core.
// Holds the PC, selects the next PC (jr > jump > branch > pc+4), drives the
// instruction-memory address and registers the fetched word into IF/ID.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   stall                hazard hold: freezes PC and IF/ID, redirects ignored
//   br_taken, pc_branch  ID-stage taken branch and its target
//   jump, pc_jump        J/JAL in ID and its target
//   jr, pc_jr            JR/JALR in ID and the forwarded rs value
//   imem                 instruction-memory bus (addr = pc, rdata combinational)
//   pc, pc4              current fetch PC and pc + 4
//   id_instr, id_pc,
//   id_pc4, id_valid     IF/ID pipeline register
//
// Configuration macro IF_FLUSH_EN: when defined, the instruction fetched on a
// redirect edge is squashed (NOP, id_valid = 0) instead of executing as a
// delay slot.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [31:0]       pc_branch,
    input  logic              jump,
    input  logic [31:0]       pc_jump,
    input  logic              jr,
    input  logic [31:0]       pc_jr,
    if_stage_if.master        imem,
    output logic [31:0]       pc,
    output logic [31:0]       pc4,
    output logic [31:0]       id_instr,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_pc4,
    output logic              id_valid
);

    typedef enum logic {ST_RESET, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic        load;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_next;

    assign pc4       = pc + 32'd4;
    assign imem.addr = pc;

    // The first edge after reset release already fetches RESET_PC into
    // IF/ID, so both states load whenever the hazard unit allows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_RESET: begin
                load    = !stall;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                load    = !stall;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_comb begin
        if (jr)            target = pc_jr;
        else if (jump)     target = pc_jump;
        else if (br_taken) target = pc_branch;
        else               target = pc4;
    end

    // Word-align whatever source was selected; low bits of pc_jr may be junk.
    assign pc_next  = target & ~32'd3;
    assign redirect = jr | jump | br_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            id_instr <= 32'd0;
            id_pc    <= 32'd0;
            id_pc4   <= 32'd0;
            id_valid <= 1'b0;
        end else if (load) begin
            pc       <= pc_next;
            id_pc    <= pc;
            id_pc4   <= pc4;
`ifdef IF_FLUSH_EN
            id_instr <= redirect ? 32'd0 : imem.rdata;
            id_valid <= !redirect;
`else
            id_instr <= imem.rdata;
            id_valid <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, branch, redirect
// priority, alignment, stall with pending redirect, PC wrap and async reset.
module tb_if_stage;

`ifdef IF_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_taken, jump, jr;
    logic [31:0] pc_branch, pc_jump, pc_jr;
    logic [31:0] pc, pc4, id_instr, id_pc, id_pc4;
    logic        id_valid;

    int checks = 0;
    int errors = 0;

    if_stage_if bus ();

    if_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .br_taken  (br_taken),
        .pc_branch (pc_branch),
        .jump      (jump),
        .pc_jump   (pc_jump),
        .jr        (jr),
        .pc_jr     (pc_jr),
        .imem      (bus.master),
        .pc        (pc),
        .pc4       (pc4),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .id_pc4    (id_pc4),
        .id_valid  (id_valid)
    );

    always #5 clk = ~clk;

    // ROM: three known words, everything else reads back 0xEE00_<addr[15:0]>.
    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h3000: rom = 32'h11;
            32'h3004: rom = 32'h22;
            32'h3008: rom = 32'h33;
            default:  rom = {16'hEE00, a[15:0]};
        endcase
    endfunction

    assign bus.rdata = rom(bus.addr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall = 0; br_taken = 0; jump = 0; jr = 0;
    endtask

    // IF/ID fields after a redirect edge depend on the delay-slot option.
    function automatic logic [31:0] slot(input logic [31:0] w);
        slot = FLUSH ? 32'd0 : w;
    endfunction

    initial begin
        rst_n = 0; clr();
        pc_branch = 0; pc_jump = 0; pc_jr = 0;
        repeat (3) step();
        chk("rst_pc",     pc,                32'h3000);
        chk("rst_pc4",    pc4,               32'h3004);
        chk("rst_addr",   bus.addr,          32'h3000);
        chk("rst_valid",  {31'd0, id_valid}, 32'd0);
        chk("rst_instr",  id_instr,          32'd0);
        chk("rst_idpc",   id_pc,             32'd0);
        chk("rst_idpc4",  id_pc4,            32'd0);

        rst_n = 1;
        step();
        chk("f0_idpc",  id_pc,             32'h3000);
        chk("f0_valid", {31'd0, id_valid}, 32'd1);
        chk("f0_pc",    pc,                32'h3004);
        chk("f0_instr", id_instr,          32'h11);
        chk("f0_idpc4", id_pc4,            32'h3004);
        step();
        chk("f1_instr", id_instr, 32'h22);
        chk("f1_idpc4", id_pc4,   32'h3008);
        chk("f1_pc",    pc,       32'h3008);

        // taken branch while pc = 0x3008
        br_taken = 1; pc_branch = 32'h3040;
        step(); clr();
        chk("br_pc",    pc,                32'h3040);
        chk("br_idpc",  id_pc,             32'h3008);
        chk("br_idpc4", id_pc4,            32'h300C);
        chk("br_instr", id_instr,          slot(32'h33));
        chk("br_valid", {31'd0, id_valid}, FLUSH ? 32'd0 : 32'd1);

        // all three redirects at once: jr wins
        jr = 1; pc_jr = 32'h3100; jump = 1; pc_jump = 32'h3200; br_taken = 1; pc_branch = 32'h3040;
        step(); clr();
        chk("pri_pc",    pc,       32'h3100);
        chk("pri_idpc",  id_pc,    32'h3040);
        chk("pri_instr", id_instr, slot(32'hEE00_3040));

        // misaligned jr target
        jr = 1; pc_jr = 32'h3103;
        step(); clr();
        chk("align_pc",   pc,    32'h3100);
        chk("align_idpc", id_pc, 32'h3100);

        // jump beats branch
        jump = 1; pc_jump = 32'h3200; br_taken = 1; pc_branch = 32'h3300;
        step(); clr();
        chk("jmp_pc",   pc,    32'h3200);
        chk("jmp_idpc", id_pc, 32'h3100);

        // stall with a pending branch for two cycles, then release
        stall = 1; br_taken = 1; pc_branch = 32'h3040;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stl_pc",    pc,                32'h3200);
            chk("stl_idpc",  id_pc,             32'h3100);
            chk("stl_instr", id_instr,          slot(32'hEE00_3100));
            chk("stl_valid", {31'd0, id_valid}, FLUSH ? 32'd0 : 32'd1);
        end
        stall = 0;
        step(); clr();
        chk("rel_pc",    pc,       32'h3040);
        chk("rel_idpc",  id_pc,    32'h3200);
        chk("rel_idpc4", id_pc4,   32'h3204);
        chk("rel_instr", id_instr, slot(32'hEE00_3200));

        // PC wrap
        jr = 1; pc_jr = 32'hFFFF_FFFC;
        step(); clr();
        chk("wrap_pc",  pc,  32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0);
        step();
        chk("wrap_next",  pc,                32'h0);
        chk("wrap_idpc",  id_pc,             32'hFFFF_FFFC);
        chk("wrap_idpc4", id_pc4,            32'h0);
        chk("wrap_instr", id_instr,          32'hEE00_FFFC);
        chk("wrap_valid", {31'd0, id_valid}, 32'd1);

        // asynchronous reset mid-cycle
        #2 rst_n = 0;
        #1;
        chk("arst_pc",    pc,                32'h3000);
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_instr", id_instr,          32'd0);
        chk("arst_idpc",  id_pc,             32'd0);
        chk("arst_idpc4", id_pc4,            32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core. It holds the program counter, selects the next PC from sequential, branch, jump and register-jump sources, and drives the instruction memory address. It registers the fetched instruction into the IF/ID pipeline register. It produces `pc4` for the branch-target adder in ID and consumes the branch target (`pc_branch`) that adder computes.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk`  input  1  pipeline clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  hazard-unit hold; freezes PC and IF/ID register.
- `br_taken`  input  1  ID-stage branch resolved taken.
- `pc_branch`  input  32  branch target from the ID-stage adder.
- `jump`  input  1  J/JAL in ID.
- `pc_jump`  input  32  jump target `{id_pc4[31:28], instr_index, 2'b00}`.
- `jr`  input  1  JR/JALR in ID.
- `pc_jr`  input  32  forwarded rs value.
- `imem_rdata`  input  32  instruction word at `imem_addr`, combinational read.
- `imem_addr`  output  32  equals `pc`.
- `pc`  output  32  current fetch PC.
- `pc4`  output  32  `pc + 4`.
- `id_instr`  output  32  IF/ID instruction.
- `id_pc`  output  32  IF/ID PC.
- `id_pc4`  output  32  IF/ID PC+4, feeds the ID branch-target adder.
- `id_valid`  output  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Next-PC select, in priority order: `jr` -> `pc_jr`; else `jump` -> `pc_jump`; else `br_taken` -> `pc_branch`; else `pc4`.
- Selected target is aligned before loading: `pc <= {target[31:2], 2'b00}`.
- `pc4 = pc + 32'd4`, modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000.
- Redirect = any of `jr`, `jump`, `br_taken` asserted while `stall` is low.
- IF/ID load when `stall` is low:
  - `id_instr <= imem_rdata`
  - `id_pc <= pc`
  - `id_pc4 <= pc4`
  - `id_valid <= 1`
- `stall` high: PC and all IF/ID fields hold. Redirect inputs are ignored that cycle. The ID stage holds its decision stable, so the redirect takes effect on the first unstalled edge.
- Control is a two-state machine: RESET (while `rst_n` is low) -> RUN (first edge after release).
  - On the first RUN edge, the instruction at `RESET_PC` enters IF/ID.
  - `id_valid` is 0 until that edge.

## Timing
- Reset values:
  - `pc` = `RESET_PC`
  - `id_instr` = 0
  - `id_pc` = 0
  - `id_pc4` = 0
  - `id_valid` = 0
- Asserting `rst_n` low mid-operation clears these immediately, regardless of `clk`.
- Fetch latency: `imem_rdata` for `pc` appears on `id_instr` one edge later.
- Redirect latency: the target is in `pc` one edge after the redirecting instruction is in ID. The instruction fetched alongside it (the delay slot) enters IF/ID on that same edge.
- Simultaneous `stall` and redirect: stall wins and nothing changes.
- Simultaneous redirects: resolved by the priority order above.

## Configuration
- `IF_FLUSH_EN` undefined (default): MIPS delay-slot semantics. The delay-slot instruction enters IF/ID normally with `id_valid = 1`.
- `IF_FLUSH_EN` defined: no delay slot. On an unstalled redirect edge, IF/ID loads `id_instr = 0` (NOP), `id_valid = 0`, and `id_pc`/`id_pc4` as usual. Stall behaviour is unchanged.

## Test plan
- Reset: hold `rst_n` low, toggle `clk`. Required: `pc` = 0x3000, `id_valid` = 0. Release reset; after one edge, `id_pc` = 0x3000, `id_valid` = 1, `pc` = 0x3004.
- Sequential fetch: ROM words 0x11, 0x22, 0x33 at 0x3000, 0x3004, 0x3008. Required: `id_instr` shows 0x11, 0x22, 0x33 on consecutive edges; `id_pc4` = 0x3004, 0x3008, 0x300C.
- Branch: `br_taken` = 1, `pc_branch` = 0x3040 for one cycle while `pc` = 0x3008. Required, next edge: `pc` = 0x3040 and `id_pc` = 0x3008. `id_valid` = 1 without `IF_FLUSH_EN`; `id_valid` = 0 and `id_instr` = 0 with it.
- Priority: `jr` = 1 (`pc_jr` = 0x3100), `jump` = 1 (`pc_jump` = 0x3200) and `br_taken` = 1 all at once. Required: `pc` = 0x3100. Separately, misaligned `pc_jr` = 0x3103 loads 0x3100.
- Stall with redirect: `stall` = 1 and `br_taken` = 1 for 2 cycles, then `stall` = 0 with `br_taken` still 1. Required: PC and IF/ID unchanged for the 2 cycles; the target is loaded on the release edge.
- Wrap and async reset: force `pc` = 0xFFFF_FFFC (`pc_jr` redirect). Required: `pc4` = 0, next `pc` = 0. Then pull `rst_n` low mid-cycle; all outputs reach reset values before the next edge.
